// File: rtl/isa_arb_pkg.sv
// Shared types and constants for the ISA bus-cycle arbiter.
package isa_arb_pkg;

    localparam int unsigned ADDR_W          = 10;
    localparam int unsigned DATA_W          = 8;
    localparam int unsigned CNT_W           = 7;
    localparam int unsigned TIMEOUT_DEFAULT = 64;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01,
        StResp = 2'b10
    } arb_state_e;

    // Index of the highest set bit; callers pass a one-hot vector.
    function automatic int unsigned onehot_idx(input logic [31:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (oh[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/isa_cycle_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester after last_winner, wrapping.
module rr_pick #(
    parameter int unsigned NReq = 3,
    parameter int unsigned IdxW = 2
) (
    input  logic [NReq-1:0] req,
    input  logic [IdxW-1:0] last_winner,
    output logic [NReq-1:0] winner,
    output logic            valid
);

    logic [IdxW-1:0] idx;
    logic            found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned k = 1; k <= NReq; k++) begin
            idx = IdxW'((32'(last_winner) + k) % NReq);
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
        valid = found;
    end

endmodule

// File: rtl/isa_cycle_arbiter.sv
// Round-robin arbiter that serialises per-port ISA I/O requests onto one bus
// cycle sequencer, with a per-cycle timeout that aborts a stuck cycle.
module isa_cycle_arbiter
    import isa_arb_pkg::*;
#(
    parameter int unsigned N_REQ   = 3,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        req_we,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]        ack,
    output logic [DATA_W-1:0]       resp_rdata,
    output logic                    resp_err,
    output logic [N_REQ-1:0]        gnt,
    output logic                    bus_rd,
    output logic                    bus_wr,
    output logic [ADDR_W-1:0]       bus_addr,
    output logic [DATA_W-1:0]       bus_wdata,
    input  logic [DATA_W-1:0]       bus_rdata,
    input  logic                    bus_done_n,
    output logic                    busy
);

    localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_e          state_q, state_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IdxW-1:0]     last_q, last_d;

    logic [N_REQ-1:0]    pick;
    logic                pick_valid;

    rr_pick #(
        .NReq (N_REQ),
        .IdxW (IdxW)
    ) u_rr_pick (
        .req         (req),
        .last_winner (last_q),
        .winner      (pick),
        .valid       (pick_valid)
    );

    // AND-OR mux of the winning port's request fields.
    logic [ADDR_W-1:0] addr_acc  [N_REQ+1];
    logic [DATA_W-1:0] wdata_acc [N_REQ+1];
    logic [N_REQ:0]    we_acc;

    assign addr_acc[0]  = '0;
    assign wdata_acc[0] = '0;
    assign we_acc[0]    = 1'b0;

    for (genvar g = 0; g < N_REQ; g++) begin : g_sel
        assign addr_acc[g+1]  = addr_acc[g] |
                                (req_addr[g*ADDR_W +: ADDR_W] & {ADDR_W{pick[g]}});
        assign wdata_acc[g+1] = wdata_acc[g] |
                                (req_wdata[g*DATA_W +: DATA_W] & {DATA_W{pick[g]}});
        assign we_acc[g+1]    = we_acc[g] | (req_we[g] & pick[g]);
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        last_d  = last_q;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    gnt_d   = pick;
                    we_d    = we_acc[N_REQ];
                    addr_d  = addr_acc[N_REQ];
                    wdata_d = wdata_acc[N_REQ];
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                // Done wins over a coincident timeout.
                if (!bus_done_n) begin
                    if (!we_q) begin
                        rdata_d = bus_rdata;
                    end
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    rdata_d = {DATA_W{1'b1}};
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StResp: begin
                gnt_d   = '0;
                last_d  = IdxW'(onehot_idx(32'(gnt_q)));
                state_d = StIdle;
            end
            default: begin
                gnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            last_q  <= IdxW'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        busy       = (state_q != StIdle);
        ack        = (state_q == StResp) ? gnt_q : '0;
        gnt        = gnt_q;
        bus_rd     = (state_q == StBusy) && !we_q;
        bus_wr     = (state_q == StBusy) && we_q;
        bus_addr   = addr_q;
        bus_wdata  = wdata_q;
        resp_rdata = rdata_q;
        resp_err   = err_q;
    end

endmodule

// File: tb/tb_isa_cycle_arbiter.sv
// Scoreboard bench for isa_cycle_arbiter: directed requests push expectations,
// a monitor checks each grant and each ack against the queue head.
module tb_isa_cycle_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  req = '0;
    logic [2:0]  req_we = '0;
    logic [29:0] req_addr = '0;
    logic [23:0] req_wdata = '0;
    logic [2:0]  ack;
    logic [7:0]  resp_rdata;
    logic        resp_err;
    logic [2:0]  gnt;
    logic        bus_rd;
    logic        bus_wr;
    logic [9:0]  bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata = '0;
    logic        bus_done_n = 1'b1;
    logic        busy;

    isa_cycle_arbiter #(
        .N_REQ   (3),
        .TIMEOUT (64)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .ack        (ack),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .gnt        (gnt),
        .bus_rd     (bus_rd),
        .bus_wr     (bus_wr),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_done_n (bus_done_n),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         port;
        logic       we;
        logic [9:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        logic       err;
        int         len;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   done_at = 0;     // BUSY cycle in which the sequencer model strobes done; 0 = never
    bit   idle_done = 1'b0; // hold done low outside BUSY to show it is ignored
    int   bcnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sequencer model: counts command cycles and strobes done in cycle done_at.
    initial forever begin
        @(posedge clk);
        #1;
        if (bus_rd || bus_wr) begin
            bcnt++;
            bus_done_n = (done_at != 0 && bcnt == done_at) ? 1'b0 : 1'b1;
        end else begin
            bcnt = 0;
            bus_done_n = idle_done ? 1'b0 : 1'b1;
        end
    end

    // Requesters drop their level once acknowledged.
    initial forever begin
        @(negedge clk);
        req = req & ~ack;
    end

    // Monitor / scoreboard.
    bit         prev_cmd = 1'b0;
    bit         prev_busy = 1'b0;
    bit         addr_changed = 1'b0;
    logic [9:0] grant_addr = '0;
    int         run = 0;
    exp_t       e;

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            prev_cmd  = 1'b0;
            prev_busy = 1'b0;
            run       = 0;
        end else begin
            if ((bus_rd || bus_wr) && !prev_cmd) begin
                check("idle_before_grant", 32'(prev_busy), 32'd0);
                if (q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_grant: gnt=%b, expected no grant", gnt);
                end else begin
                    e = q[0];
                    check("gnt", 32'(gnt), 32'(1) << e.port);
                    check("bus_addr", 32'(bus_addr), 32'(e.addr));
                    check("bus_rd", 32'(bus_rd), 32'(!e.we));
                    check("bus_wr", 32'(bus_wr), 32'(e.we));
                    if (e.we) check("bus_wdata", 32'(bus_wdata), 32'(e.wdata));
                end
                grant_addr   = bus_addr;
                addr_changed = 1'b0;
                run          = 1;
            end else if (bus_rd || bus_wr) begin
                run++;
                if (bus_addr !== grant_addr) addr_changed = 1'b1;
            end
            if (ack != 0) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_ack: ack=%b, expected none", ack);
                end else begin
                    e = q.pop_front();
                    check("ack", 32'(ack), 32'(1) << e.port);
                    check("resp_err", 32'(resp_err), 32'(e.err));
                    if (!e.we || e.err) check("resp_rdata", 32'(resp_rdata), 32'(e.rdata));
                    check("cmd_cycles", 32'(run), 32'(e.len));
                    check("cmd_off_in_resp", 32'({bus_rd, bus_wr}), 32'd0);
                    check("addr_stable", 32'(addr_changed), 32'd0);
                end
            end
            prev_cmd  = bus_rd || bus_wr;
            prev_busy = busy;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic issue(input int port, input bit we, input logic [9:0] addr,
                         input logic [7:0] wd, input logic [7:0] rd, input bit err,
                         input int len);
        exp_t x;
        req_we[port]              = we;
        req_addr[port*10 +: 10]   = addr;
        req_wdata[port*8 +: 8]    = wd;
        req[port]                 = 1'b1;
        x = '{port, we, addr, wd, rd, err, len};
        q.push_back(x);
    endtask

    task automatic wait_drain(input int budget);
        int c = 0;
        while ((q.size() != 0 || busy) && c < budget) begin
            tick();
            c++;
        end
        if (c >= budget) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: %0d pending after %0d cycles, expected 0", q.size(),
                     budget);
            q.delete();
            req = '0;
        end
        tick(2);
    endtask

    task automatic wait_cmd(input int budget);
        int c = 0;
        while (!(bus_rd || bus_wr) && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (c >= budget) begin
            n_checks++;
            n_errors++;
            $display("FAIL grant_timeout: no command after %0d cycles, expected one", budget);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        tick(3);
        @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_bus_rd", 32'(bus_rd), 32'd0);
        check("rst_bus_wr", 32'(bus_wr), 32'd0);
        check("rst_bus_addr", 32'(bus_addr), 32'd0);
        check("rst_bus_wdata", 32'(bus_wdata), 32'd0);
        check("rst_resp_rdata", 32'(resp_rdata), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        tick(1);
        reset = 1'b1;
        tick(1);

        // Port1 read, done in BUSY cycle 7.
        bus_rdata = 8'hAA;
        done_at   = 7;
        issue(1, 1'b0, 10'h22C, 8'h00, 8'hAA, 1'b0, 7);
        wait_drain(200);

        // Three simultaneous writes after reset: grants 0,1,2.
        do_reset();
        bus_rdata = 8'h00;
        done_at   = 3;
        issue(0, 1'b1, 10'h300, 8'h11, 8'h00, 1'b0, 3);
        issue(1, 1'b1, 10'h301, 8'h22, 8'h00, 1'b0, 3);
        issue(2, 1'b1, 10'h302, 8'h33, 8'h00, 1'b0, 3);
        wait_drain(200);

        // Sequencer never finishes: timeout after 64 cycles.
        bus_rdata = 8'h5A;
        done_at   = 0;
        issue(0, 1'b0, 10'h123, 8'h00, 8'hFF, 1'b1, 64);
        wait_drain(300);

        // Done one cycle before the timeout limit.
        bus_rdata = 8'h3C;
        done_at   = 63;
        issue(0, 1'b0, 10'h0F0, 8'h00, 8'h3C, 1'b0, 63);
        wait_drain(300);

        // Done coincides with the final timeout cycle: done wins.
        bus_rdata = 8'h5C;
        done_at   = 64;
        issue(1, 1'b0, 10'h1F0, 8'h00, 8'h5C, 1'b0, 64);
        wait_drain(300);

        // Reset during BUSY cycle 3 of a port2 write.
        done_at = 0;
        issue(2, 1'b1, 10'h3FF, 8'hC3, 8'h00, 1'b0, 0);
        wait_cmd(20);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_wr_before_edge", 32'(bus_wr), 32'd1);
        @(negedge clk);
        check("abort_wr_dropped", 32'(bus_wr), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_no_ack", 32'(ack), 32'd0);
        req = '0;
        q.delete();
        tick(1);
        reset = 1'b1;
        tick(1);
        bus_rdata = 8'h77;
        done_at   = 2;
        issue(0, 1'b0, 10'h010, 8'h00, 8'h77, 1'b0, 2);
        issue(2, 1'b1, 10'h020, 8'h99, 8'h00, 1'b0, 2);
        wait_drain(200);

        // Port2 drops req mid-cycle while port0 raises; done strobes outside BUSY ignored.
        idle_done = 1'b1;
        bus_rdata = 8'h4E;
        done_at   = 10;
        issue(2, 1'b0, 10'h2A5, 8'h00, 8'h4E, 1'b0, 10);
        wait_cmd(20);
        tick(2);
        issue(0, 1'b1, 10'h155, 8'h66, 8'h00, 1'b0, 10);
        tick(2);
        req[2] = 1'b0;
        wait_drain(300);
        idle_done = 1'b0;

        tick(3);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
